local_memory_arbiter: RTL and testbench
=======================================

Name: local_memory_arbiter

Overview:
- Round-robin arbiter sharing one port of the dual-port local memory between NUM_REQ requesters (e.g. accelerator actors vs. the config/DMA side).
- Grants one access per cycle and drives the memory port's ce/rden/wren/address/data_in.
- Returns read data with a per-requester valid pulse one cycle after the access.
- A granted requester may hold the port for up to MAX_BURST consecutive beats while others wait.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
SIZE_WORD, 32, memory word width
SIZE_ADDR, 8, memory address width
MAX_BURST, 4, max consecutive beats for one owner while others are pending (>=1)

Ports:
aclk  in  1  clock; single clock domain shared with the memory port
areset  in  1  synchronous, active-high reset
req  in  NUM_REQ  access request, one bit per requester
we  in  NUM_REQ  1 = write, 0 = read, qualified by req
addr  in  NUM_REQ*SIZE_ADDR  flattened addresses; requester i uses bits [i*SIZE_ADDR +: SIZE_ADDR]
wdata  in  NUM_REQ*SIZE_WORD  flattened write data, same slicing
gnt  out  NUM_REQ  one-hot grant, combinational; a beat completes in any cycle where req[i] & gnt[i]
rvalid  out  NUM_REQ  registered, one-hot; read data valid for requester i
rdata  out  SIZE_WORD  read data, equal to mem_data_out; meaningful only while rvalid is nonzero
mem_ce  out  1  memory port chip enable
mem_rden  out  1  memory read enable
mem_wren  out  1  memory write enable
mem_address  out  SIZE_ADDR  memory address
mem_data_in  out  SIZE_WORD  memory write data
mem_data_out  in  SIZE_WORD  memory registered read data

Behaviour:
- Registered state:
  - owner: index of the current owner.
  - own_vld: state IDLE (0) or BUSY (1).
  - last: index of the last granted requester.
  - beat_cnt: width $clog2(MAX_BURST+1).
  - rvalid.
- Reset (areset=1 at a clock edge):
  - own_vld=0, owner=0, last=NUM_REQ-1 so requester 0 has top priority, beat_cnt=0, rvalid=0.
  - While areset is high, gnt=0 and mem_ce/mem_rden/mem_wren=0 regardless of req.
- Grant selection (combinational, each cycle):
  - Keep the current owner if BUSY, req[owner]=1, and either beat_cnt<MAX_BURST or no other req bit is set.
  - Otherwise grant the first set req bit scanning last+1, last+2, … (mod NUM_REQ).
  - If req==0, then gnt=0.
- Memory drive:
  - mem_ce = |gnt.
  - mem_wren = we[g].
  - mem_rden = ~we[g].
  - mem_address = addr slice of g; mem_data_in = wdata slice of g, where g is the granted index.
  - When gnt=0, all memory enables are 0; address/data are don't-care but must be held stable (drive slice 0).
- State transitions at each clock edge:
  - IDLE -> BUSY when any grant is given: owner=g, last=g, beat_cnt=1.
  - BUSY, same owner re-granted: beat_cnt+1. If beat_cnt was MAX_BURST (possible only when no other request is pending), beat_cnt restarts at 1.
  - BUSY, grant moves to a different requester: owner=g, last=g, beat_cnt=1.
  - BUSY -> IDLE when gnt=0: beat_cnt=0, last unchanged.
- Read return:
  - rvalid[i] <= gnt[i] & ~we[i] (registered).
  - Latency: rvalid and rdata follow the read beat by exactly one cycle.
  - Back-to-back reads give back-to-back rvalid.
  - Write beats never produce rvalid.
- Write-then-read:
  - A read in the cycle after a write to the same address returns the new data.
  - Data returned during the write cycle itself is the memory's read-first old value and is not flagged by rvalid.
- Requester obligations:
  - Hold req, we, addr, wdata stable until granted.
  - Dropping req before grant is legal; no beat occurs.
- Reset mid-burst:
  - Any beat in the areset cycle is suppressed.
  - rvalid goes to 0 on the next edge; a pending read return is discarded.
- No starvation: with all requesters continuously requesting, each gets MAX_BURST beats in a round of NUM_REQ*MAX_BURST cycles.

Test Plan:
1. Reset with req=4'b1111 -> gnt=0, mem_ce=0 during reset. First cycle after reset: gnt=4'b0001, owner=0, beat_cnt=1 at the next edge.
2. Requester 2 writes 0xDEADBEEF to addr 0x10, then the next cycle reads 0x10 (others idle) -> gnt[2] both cycles; rvalid=4'b0100 one cycle after the read with rdata=0xDEADBEEF; no rvalid after the write.
3. MAX_BURST=4, req=4'b1111 held for 16 reads -> grants are 0×4, 1×4, 2×4, 3×4; rvalid mirrors gnt delayed by one cycle.
4. Only requester 1 requests for 10 beats -> gnt[1] every cycle, no rotation, beat_cnt wraps 4->1.
5. Owner 3 after 2 beats, then req[3] drops while req[0] and req[1] are set -> grant to 0 (scan from last+1 = 0), beat_cnt=1.
6. areset asserted during a read beat of requester 1 -> no rvalid the following cycle; state IDLE with last=3; next req=4'b0010 is granted immediately.

Source files
------------

// File: rtl/local_memory_arbiter.sv
// Round-robin arbiter sharing one local-memory port between NUM_REQ requesters,
// with bounded bursts per owner and a one-cycle registered read-valid return.
//
// state | meaning
// IDLE  | no owner; next grant comes from the round-robin scan
// BUSY  | r_owner was granted last cycle; may keep the port while its burst allows
module local_memory_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_WORD = 32,
    parameter int SIZE_ADDR = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                           i_aclk,
    input  logic                           i_areset,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ-1:0]             i_we,
    input  logic [NUM_REQ*SIZE_ADDR-1:0]   i_addr,
    input  logic [NUM_REQ*SIZE_WORD-1:0]   i_wdata,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic [NUM_REQ-1:0]             o_rvalid,
    output logic [SIZE_WORD-1:0]           o_rdata,
    output logic                           o_mem_ce,
    output logic                           o_mem_rden,
    output logic                           o_mem_wren,
    output logic [SIZE_ADDR-1:0]           o_mem_address,
    output logic [SIZE_WORD-1:0]           o_mem_data_in,
    input  logic [SIZE_WORD-1:0]           i_mem_data_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     w_owner_nxt;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     w_last_nxt;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic [CNT_W-1:0]     w_beat_cnt_nxt;
    logic [NUM_REQ-1:0]   r_rvalid;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [NUM_REQ-1:0]   w_owner_mask;
    logic [IDX_W-1:0]     w_gidx;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_gvld;
    logic                 w_others;
    logic                 w_keep;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    // Owner keeps the port until its burst is used up, unless nobody else is waiting.
    always_comb begin
        w_owner_mask          = '0;
        w_owner_mask[r_owner] = 1'b1;
        w_others = |(i_req & ~w_owner_mask);
        w_keep   = (r_state == BUSY) && i_req[r_owner] &&
                   ((r_beat_cnt < CNT_W'(MAX_BURST)) || !w_others);
        w_gvld   = 1'b0;
        w_gidx   = r_owner;
        if (w_keep) begin
            w_gvld = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!w_gvld && i_req[wrap_add(r_last, k)]) begin
                    w_gvld = 1'b1;
                    w_gidx = wrap_add(r_last, k);
                end
            end
        end
        if (i_areset) w_gvld = 1'b0;
        w_gnt = '0;
        if (w_gvld) w_gnt[w_gidx] = 1'b1;
    end

    // Slice 0 is selected when idle so the address/data bus does not toggle.
    assign w_sel         = w_gvld ? w_gidx : '0;
    assign o_gnt         = w_gnt;
    assign o_mem_ce      = w_gvld;
    assign o_mem_wren    = w_gvld &  i_we[w_sel];
    assign o_mem_rden    = w_gvld & ~i_we[w_sel];
    assign o_mem_address = i_addr[w_sel*SIZE_ADDR +: SIZE_ADDR];
    assign o_mem_data_in = i_wdata[w_sel*SIZE_WORD +: SIZE_WORD];
    assign o_rvalid      = r_rvalid;
    assign o_rdata       = i_mem_data_out;

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_gvld) begin
                    w_state_nxt    = BUSY;
                    w_owner_nxt    = w_gidx;
                    w_last_nxt     = w_gidx;
                    w_beat_cnt_nxt = CNT_W'(1);
                end
            end
            BUSY: begin
                if (!w_gvld) begin
                    w_state_nxt    = IDLE;
                    w_beat_cnt_nxt = '0;
                end else if (w_gidx == r_owner) begin
                    // A full burst with no competition starts a fresh burst.
                    if (r_beat_cnt == CNT_W'(MAX_BURST))
                        w_beat_cnt_nxt = CNT_W'(1);
                    else
                        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end else begin
                    w_owner_nxt    = w_gidx;
                    w_last_nxt     = w_gidx;
                    w_beat_cnt_nxt = CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
            r_rvalid   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_rvalid   <= w_gnt & ~i_we;
        end
    end

endmodule

// File: tb/tb_local_memory_arbiter.sv
// Self-checking bench for local_memory_arbiter: directed scenarios plus random
// traffic compared against a behavioural arbitration/memory model.
module tb_local_memory_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int A  = 8;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             areset;
    logic [N-1:0]     req, we, gnt, rvalid;
    logic [N*A-1:0]   addr;
    logic [N*W-1:0]   wdata;
    logic [W-1:0]     rdata, mem_data_in, mem_dout;
    logic             mem_ce, mem_rden, mem_wren;
    logic [A-1:0]     mem_address;
    logic [W-1:0]     dev_mem [0:255];

    int total = 0;
    int bad   = 0;

    // reference model state
    bit               m_busy;
    int               m_owner, m_last, m_cnt;
    logic [N-1:0]     m_rvalid;
    logic [W-1:0]     m_rdata;
    bit               m_rdata_known;
    logic [W-1:0]     shadow [0:255];
    bit               shadow_vld [0:255];

    always #5 clk = ~clk;

    // read-first synchronous memory
    always @(posedge clk) begin
        if (mem_ce) begin
            mem_dout <= dev_mem[mem_address];
            if (mem_wren) dev_mem[mem_address] <= mem_data_in;
        end
    end

    local_memory_arbiter #(.NUM_REQ(N), .SIZE_WORD(W), .SIZE_ADDR(A), .MAX_BURST(MB)) dut (
        .i_aclk(clk), .i_areset(areset), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_mem_ce(mem_ce), .o_mem_rden(mem_rden),
        .o_mem_wren(mem_wren), .o_mem_address(mem_address), .o_mem_data_in(mem_data_in),
        .i_mem_data_out(mem_dout)
    );

    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] rq, input bit rst);
        logic [N-1:0] r;
        int others;
        r = '0;
        if (rst || rq == '0) return r;
        others = 0;
        for (int i = 0; i < N; i++) if (rq[i] && i != m_owner) others++;
        if (m_busy && rq[m_owner] && (m_cnt < MB || others == 0)) begin
            r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 1; k <= N; k++) begin
            if (rq[(m_last + k) % N]) begin
                r[(m_last + k) % N] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
        m_rvalid = '0; m_rdata_known = 0;
    endtask

    // advance one clock edge and move the model with it
    task automatic tick();
        logic [N-1:0] g;
        int gi;
        logic [A-1:0] a;
        g = model_gnt(req, areset);
        @(posedge clk);
        if (areset) begin
            model_reset();
        end else if (g == '0) begin
            m_busy = 0; m_cnt = 0; m_rvalid = '0;
        end else begin
            gi = 0;
            for (int i = 0; i < N; i++) if (g[i]) gi = i;
            if (m_busy && gi == m_owner) m_cnt = (m_cnt == MB) ? 1 : m_cnt + 1;
            else begin m_owner = gi; m_last = gi; m_cnt = 1; end
            m_busy = 1;
            a = addr[gi*A +: A];
            if (we[gi]) begin
                shadow[a] = wdata[gi*W +: W]; shadow_vld[a] = 1; m_rvalid = '0;
            end else begin
                m_rvalid = g; m_rdata = shadow[a]; m_rdata_known = shadow_vld[a];
            end
        end
        #1;
    endtask

    task automatic set_port(input int i, input logic w, input logic [A-1:0] ad, input logic [W-1:0] d);
        we[i] = w;
        addr[i*A +: A] = ad;
        wdata[i*W +: W] = d;
    endtask

    task automatic test_reset();
        areset = 1'b1; req = 4'b1111; we = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
            total++; if (mem_ce !== 1'b0) begin bad++; $display("FAIL rst_ce: got %b want 0", mem_ce); end
            if (c > 0) begin
                total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL rst_rvalid: got %b want 0000", rvalid); end
            end
            tick();
        end
        areset = 1'b0;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL first_gnt: got %b want 0001", gnt); end
        total++; if (mem_rden !== 1'b1) begin bad++; $display("FAIL first_rden: got %b want 1", mem_rden); end
        tick();
        @(negedge clk);
        total++; if (rvalid !== 4'b0001) begin bad++; $display("FAIL first_rvalid: got %b want 0001", rvalid); end
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL first_keep: got %b want 0001", gnt); end
        req = '0;
        tick();
    endtask

    task automatic test_write_read();
        req = 4'b0100;
        set_port(2, 1'b1, 8'h10, 32'hDEADBEEF);
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL wr_gnt: got %b want 0100", gnt); end
        total++; if (mem_wren !== 1'b1 || mem_rden !== 1'b0) begin bad++; $display("FAIL wr_en: got wren=%b rden=%b want 1/0", mem_wren, mem_rden); end
        total++; if (mem_address !== 8'h10) begin bad++; $display("FAIL wr_addr: got %h want 10", mem_address); end
        total++; if (mem_data_in !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data: got %h want deadbeef", mem_data_in); end
        tick();
        set_port(2, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rd_gnt: got %b want 0100", gnt); end
        total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL wr_no_rvalid: got %b want 0000", rvalid); end
        tick();
        req = '0;
        @(negedge clk);
        total++; if (rvalid !== 4'b0100) begin bad++; $display("FAIL rd_rvalid: got %b want 0100", rvalid); end
        total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rdata); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g, prev_g;
        areset = 1'b1; req = '0; tick(); areset = 1'b0;
        prev_g = '0;
        for (int c = 0; c < 16; c++) begin
            req = 4'b1111;
            for (int i = 0; i < N; i++) set_port(i, 1'b0, A'($urandom_range(0, 16)), 32'h0);
            exp_g = 4'b0001 << (c / 4);
            @(negedge clk);
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt, exp_g); end
            if (c > 0) begin
                total++; if (rvalid !== prev_g) begin bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", c, rvalid, prev_g); end
                if (m_rdata_known) begin
                    total++; if (rdata !== m_rdata) begin bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", c, rdata, m_rdata); end
                end
            end
            prev_g = exp_g;
            tick();
        end
        req = '0;
        @(negedge clk);
        total++; if (rvalid !== 4'b1000) begin bad++; $display("FAIL rr_last_rvalid: got %b want 1000", rvalid); end
        tick();
    endtask

    task automatic test_single_burst();
        logic [N-1:0] exp_tail [0:2];
        exp_tail[0] = 4'b0010; exp_tail[1] = 4'b0010; exp_tail[2] = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            req = 4'b0010;
            set_port(1, 1'b0, A'($urandom_range(0, 16)), 32'h0);
            @(negedge clk);
            total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL solo_gnt[%0d]: got %b want 0010", c, gnt); end
            tick();
        end
        // after 10 beats the burst count has wrapped to 2: two more beats before rotation
        for (int c = 0; c < 3; c++) begin
            req = 4'b0011;
            set_port(0, 1'b0, 8'h10, 32'h0);
            @(negedge clk);
            total++; if (gnt !== exp_tail[c]) begin bad++; $display("FAIL solo_tail[%0d]: got %b want %b", c, gnt, exp_tail[c]); end
            total++; if (rvalid !== m_rvalid) begin bad++; $display("FAIL solo_rvalid[%0d]: got %b want %b", c, rvalid, m_rvalid); end
            tick();
        end
        req = '0; tick();
    endtask

    task automatic test_drop_owner();
        areset = 1'b1; req = '0; tick(); areset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            req = 4'b1000;
            set_port(3, 1'b0, 8'h10, 32'h0);
            @(negedge clk);
            total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL drop_own[%0d]: got %b want 1000", c, gnt); end
            tick();
        end
        req = 4'b0011;
        set_port(0, 1'b0, 8'h01, 32'h0);
        set_port(1, 1'b0, 8'h02, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL drop_next[%0d]: got %b want 0001", c, gnt); end
            tick();
        end
        req = '0; tick();
    endtask

    task automatic test_reset_mid_burst();
        req = 4'b0010;
        set_port(1, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_pre_gnt: got %b want 0010", gnt); end
        tick();
        areset = 1'b1;
        @(negedge clk);
        total++; if (gnt !== 4'b0000 || mem_ce !== 1'b0) begin bad++; $display("FAIL mid_rst_gnt: got gnt=%b ce=%b want 0000/0", gnt, mem_ce); end
        tick();
        areset = 1'b0;
        @(negedge clk);
        total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL mid_rvalid: got %b want 0000", rvalid); end
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_regrant: got %b want 0010", gnt); end
        tick();
        req = '0; tick();
    endtask

    task automatic test_random();
        bit           pend [N];
        logic [N-1:0] exp_g;
        int           gi;
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 400; c++) begin
            areset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    set_port(i, 1'($urandom_range(0, 1)), A'($urandom_range(0, 15)), $urandom);
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 0;
                end
                req[i] = pend[i];
            end
            exp_g = model_gnt(req, areset);
            @(negedge clk);
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, gnt, exp_g); end
            total++; if (mem_ce !== (exp_g != '0)) begin bad++; $display("FAIL rnd_ce[%0d]: got %b want %b", c, mem_ce, exp_g != '0); end
            if (exp_g != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (exp_g[i]) gi = i;
                total++;
                if (mem_wren !== we[gi] || mem_rden !== ~we[gi] || mem_address !== addr[gi*A +: A] ||
                    mem_data_in !== wdata[gi*W +: W]) begin
                    bad++;
                    $display("FAIL rnd_port[%0d]: got wren=%b addr=%h data=%h want wren=%b addr=%h data=%h",
                             c, mem_wren, mem_address, mem_data_in, we[gi], addr[gi*A +: A], wdata[gi*W +: W]);
                end
            end
            total++; if (rvalid !== m_rvalid) begin bad++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, rvalid, m_rvalid); end
            if (m_rvalid != '0 && m_rdata_known) begin
                total++; if (rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata, m_rdata); end
            end
            tick();
            for (int i = 0; i < N; i++) if (exp_g[i]) pend[i] = 0;
        end
        areset = 1'b0; req = '0; tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            shadow[i] = '0;
            shadow_vld[i] = 0;
        end
        model_reset();
        areset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_single_burst();
        test_drop_owner();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
